// File: rtl/cpu_control_fsm_if.sv
// Instruction-fetch bus between the control sequencer and the instruction memory / IR.
// The master side (sequencer) requests fetches and strobes the IR; the slave side answers.
interface cpu_control_fsm_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic            ir_we;
    logic [2:0]      opcode;

    modport master (
        output imem_req,
        output imem_addr,
        output ir_we,
        input  imem_ack,
        input  opcode
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        input  ir_we,
        output imem_ack,
        output opcode
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 9-bit-instruction core.
// Owns the program counter, the latched ALU op and a saturating retired-instruction counter.
module cpu_control_fsm #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    cpu_control_fsm_if.master    bus,
    output logic [2:0]           alu_op,
    output logic                 rf_we,
    output logic [PC_W-1:0]      pc,
    output logic                 halted,
    output logic                 busy,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t            state_r;
    state_t            next_state_s;
    logic [PC_W-1:0]   pc_r;
    logic [2:0]        alu_op_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              pc_inc_s;
    logic              pc_clr_s;
    logic              alu_ld_s;
    logic              cnt_inc_s;

    logic              imem_req_s;
    logic              ir_we_s;
    logic              rf_we_s;
    logic              halted_s;
    logic              busy_s;

    // Counter stops at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection and datapath update enables.
    always_comb begin
        next_state_s = state_r;
        pc_inc_s     = 1'b0;
        pc_clr_s     = 1'b0;
        alu_ld_s     = 1'b0;
        cnt_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    pc_inc_s     = 1'b1;
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (bus.opcode == OP_HALT) begin
                    next_state_s = ST_HALT;
                end else if (bus.opcode == OP_NOP) begin
                    cnt_inc_s    = 1'b1;
                    next_state_s = ST_FETCH;
                end else begin
                    alu_ld_s     = 1'b1;
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                next_state_s = ST_WB;
            end
            ST_WB: begin
                cnt_inc_s    = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_HALT: begin
                // Restart from address zero; the retired count is kept across runs.
                if (start) begin
                    pc_clr_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Program counter: advances once per accepted fetch, wraps at 2^PC_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= {PC_W{1'b0}};
        end else if (pc_clr_s) begin
            pc_r <= {PC_W{1'b0}};
        end else if (pc_inc_s) begin
            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    // ALU op is captured at decode and held until the next ALU instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_r <= 3'b000;
        end else if (alu_ld_s) begin
            alu_op_r <= bus.opcode;
        end else begin
            alu_op_r <= alu_op_r;
        end
    end

    // Retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= sat_inc(cnt_r);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Moore strobes decoded from the state register; ir_we also gates on the live ack.
    always_comb begin
        imem_req_s = 1'b0;
        ir_we_s    = 1'b0;
        rf_we_s    = 1'b0;
        halted_s   = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_FETCH: begin
                imem_req_s = 1'b1;
                ir_we_s    = bus.imem_ack;
                busy_s     = 1'b1;
            end
            ST_DECODE: begin
                busy_s = 1'b1;
            end
            ST_EXEC: begin
                busy_s = 1'b1;
            end
            ST_WB: begin
                rf_we_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.imem_req  = imem_req_s;
    assign bus.imem_addr = pc_r;
    assign bus.ir_we     = ir_we_s;
    assign alu_op        = alu_op_r;
    assign rf_we         = rf_we_s;
    assign pc            = pc_r;
    assign halted        = halted_s;
    assign busy          = busy_s;
    assign instr_count   = cnt_r;

endmodule
